uart_rx_frame_ctrl: RTL and testbench

//  Framing controller behind uart_ctrl_rx: consumes the 1-cycle rcv strobe plus data byte, and parses

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 23 ++
 rtl/uart_rx_frame_ctrl_if.sv | 34 +++
 rtl/uart_frame_buf.sv | 37 +++
 rtl/uart_rx_frame_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive framing controller.
//   SOF_DEFAULT : default start-of-frame byte
//   ERR_*       : err_code values reported with the err pulse
//   state_e     : frame parser states
package uart_rx_frame_ctrl_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TMO  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CSUM,
    S_HOLD
  } state_e;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-in / frame-out bus of the UART receive framing controller.
//   rcv, data            : received byte strobe and value (from the UART receiver)
//   frm_valid, frm_ack   : held-frame handshake with the command layer
//   frm_cmd, frm_len     : CMD and LEN of the held frame
//   rd_addr, rd_data     : payload read port (registered, 1-cycle latency)
//   err, err_code, ovr   : abort and overrun pulses
//   busy                 : parser not idle
// modport slave is the framing controller, modport master its environment.
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned AW = 4
);
  logic          rcv;
  logic [7:0]    data;
  logic          frm_valid;
  logic          frm_ack;
  logic [7:0]    frm_cmd;
  logic [7:0]    frm_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err;
  logic [1:0]    err_code;
  logic          ovr;
  logic          busy;

  modport slave (
    input  rcv, data, frm_ack, rd_addr,
    output frm_valid, frm_cmd, frm_len, rd_data, err, err_code, ovr, busy
  );

  modport master (
    output rcv, data, frm_ack, rd_addr,
    input  frm_valid, frm_cmd, frm_len, rd_data, err, err_code, ovr, busy
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 RAM, one write port, one registered read port.
//   clk, rstn      : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, rdata = mem[raddr] one cycle later
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_d;
  logic [7:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rd_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign rdata = rd_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framing controller. Parses SOF|CMD|LEN|PAYLOAD[LEN]|CSUM from
// the receiver's byte strobe, buffers the payload, checks the 8-bit additive
// checksum (CMD+LEN+PAYLOAD+CSUM == 0 mod 256) and holds good frames until
// the command layer acknowledges them.
//   clk, rstn : clock, async active-low reset
//   bus       : byte input, frame handshake, payload read port and status pulses
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter logic [7:0]  SOF     = SOF_DEFAULT,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 12000
) (
  input  logic                   clk,
  input  logic                   rstn,
  uart_rx_frame_ctrl_if.slave    bus
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            ovr_q, ovr_d;
  logic            wr_en;
  logic [7:0]      csum_chk;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    ovr_d    = 1'b0;
    wr_en    = 1'b0;
    csum_chk = sum_q + bus.data;

    unique case (state_q)
      S_IDLE: begin
        // A SOF landing in the cycle the abort pulse is visible is dropped.
        if (bus.rcv && bus.data == SOF && !err_q) state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.rcv) begin
          cmd_d   = bus.data;
          sum_d   = bus.data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (bus.rcv) begin
          if (bus.data > MAX_LEN_B) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            len_d   = bus.data;
            sum_d   = sum_q + bus.data;
            cnt_d   = '0;
            state_d = (bus.data == 8'd0) ? S_CSUM : S_PAY;
          end
        end
      end
      S_PAY: begin
        if (bus.rcv) begin
          wr_en = 1'b1;
          sum_d = sum_q + bus.data;
          cnt_d = cnt_q + AW'(1);
          if (8'(cnt_q) == len_q - 8'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (bus.rcv) begin
          if (csum_chk == 8'd0) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
      end
      S_HOLD: begin
        // Ack takes priority; the same-cycle byte is then treated as in IDLE.
        if (bus.frm_ack) begin
          state_d = (bus.rcv && bus.data == SOF) ? S_CMD : S_IDLE;
        end else if (bus.rcv) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timer: only runs inside a frame, a received byte always wins.
    if (state_q inside {S_CMD, S_LEN, S_PAY, S_CSUM}) begin
      if (bus.rcv) begin
        timer_d = '0;
      end else if (timer_q == TMO_LAST) begin
        timer_d = '0;
        state_d = S_IDLE;
        err_d   = 1'b1;
        code_d  = ERR_TMO;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_en),
    .waddr (cnt_q),
    .wdata (bus.data),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.frm_valid = (state_q == S_HOLD);
  assign bus.frm_cmd   = cmd_q;
  assign bus.frm_len   = len_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.ovr       = ovr_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames with literal expectations,
// then randomized byte streams checked every cycle against a frame-level model.
module tb_uart_rx_frame_ctrl;

  localparam int          MAX_LEN = 16;
  localparam int          TIMEOUT = 200;
  localparam logic [7:0]  SOF     = 8'hAA;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if #(.AW(4)) bus ();

  uart_rx_frame_ctrl #(
    .SOF     (SOF),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit rd_rand  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit          m_in    = 0;   // inside a frame (after SOF)
  bit          m_hold  = 0;   // good frame held
  byte unsigned m_fr[$];      // bytes received after SOF
  int          m_quiet = 0;   // idle cycles since last byte in frame
  int          m_cmd   = 0;
  int          m_len   = 0;
  int          m_pay [MAX_LEN];
  bit          m_err   = 0;
  int          m_code  = 0;
  bit          m_ovr   = 0;
  bit          m_chk_rd = 0;
  int          m_rd    = 0;

  task automatic model_clear();
    m_in = 0; m_hold = 0; m_fr.delete(); m_quiet = 0;
    m_err = 0; m_code = 0; m_ovr = 0; m_chk_rd = 0;
  endtask

  // Advance the model over the next clock edge using the inputs presented now.
  task automatic model_step();
    bit n_err;
    int n_code;
    bit n_ovr;
    bit r;
    int d;
    int s;
    n_err = 0; n_code = 0; n_ovr = 0;
    r = bus.rcv;
    d = int'(bus.data);
    m_chk_rd = m_hold && (int'(bus.rd_addr) < m_len);
    if (m_chk_rd) m_rd = m_pay[bus.rd_addr];
    if (m_hold) begin
      if (bus.frm_ack) begin
        m_hold = 0;
        if (r && d == SOF) begin m_in = 1; m_fr.delete(); m_quiet = 0; end
      end else if (r) begin
        n_ovr = 1;
      end
    end else if (m_in) begin
      if (r) begin
        m_fr.push_back(byte'(d));
        m_quiet = 0;
        if (m_fr.size() == 2 && d > MAX_LEN) begin
          m_in = 0; n_err = 1; n_code = 2;
        end else if (m_fr.size() >= 3 && m_fr.size() == int'(m_fr[1]) + 3) begin
          s = 0;
          foreach (m_fr[i]) s += int'(m_fr[i]);
          m_in = 0;
          if (s % 256 == 0) begin
            m_hold = 1;
            m_cmd  = m_fr[0];
            m_len  = m_fr[1];
            for (int i = 0; i < m_len; i++) m_pay[i] = m_fr[2 + i];
          end else begin
            n_err = 1; n_code = 3;
          end
        end
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT) begin m_in = 0; n_err = 1; n_code = 1; end
      end
    end else if (r && d == SOF && !m_err) begin
      m_in = 1; m_fr.delete(); m_quiet = 0;
    end
    m_err = n_err; m_code = n_code; m_ovr = n_ovr;
  endtask

  // Compare on the falling edge, then advance the model for the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        model_clear();
      end else begin
        chk("frm_valid", int'(bus.frm_valid), int'(m_hold));
        chk("busy",      int'(bus.busy),      int'(m_in || m_hold));
        chk("err",       int'(bus.err),       int'(m_err));
        chk("err_code",  int'(bus.err_code),  m_code);
        chk("ovr",       int'(bus.ovr),       int'(m_ovr));
        if (m_hold) begin
          chk("frm_cmd", int'(bus.frm_cmd), m_cmd);
          chk("frm_len", int'(bus.frm_len), m_len);
        end
        if (m_chk_rd) chk("rd_data", int'(bus.rd_data), m_rd);
        model_step();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_rand) bus.rd_addr = 4'($urandom_range(0, 15));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rcv  = 1'b1;
    bus.data = b;
    tick();
    bus.rcv  = 1'b0;
    bus.data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic do_ack();
    bus.frm_ack = 1'b1;
    tick();
    bus.frm_ack = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send_byte(q[i], gap);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] cs;
    int len;
    int kind;
    int cut;
    int gap;

    bus.rcv = 1'b0; bus.data = 8'h00; bus.frm_ack = 1'b0; bus.rd_addr = '0;
    repeat (3) tick();
    chk("rst_valid", int'(bus.frm_valid), 0);
    chk("rst_busy",  int'(bus.busy),      0);
    chk("rst_err",   int'(bus.err),       0);
    chk("rst_code",  int'(bus.err_code),  0);
    chk("rst_ovr",   int'(bus.ovr),       0);
    chk("rst_cmd",   int'(bus.frm_cmd),   0);
    chk("rst_len",   int'(bus.frm_len),   0);
    chk("rst_rd",    int'(bus.rd_data),   0);
    rstn = 1'b1;
    repeat (3) tick();

    // 1. basic frame and readback
    send_list('{8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB}, 20);
    chk("t1_valid", int'(bus.frm_valid), 1);
    chk("t1_cmd",   int'(bus.frm_cmd),   8'h10);
    chk("t1_len",   int'(bus.frm_len),   2);
    bus.rd_addr = 4'd0; tick();
    chk("t1_rd0", int'(bus.rd_data), 8'h11);
    bus.rd_addr = 4'd1; tick();
    chk("t1_rd1", int'(bus.rd_data), 8'h22);
    do_ack();
    chk("t1_ack_valid", int'(bus.frm_valid), 0);
    chk("t1_ack_busy",  int'(bus.busy),      0);
    repeat (5) tick();

    // 2. junk then zero-length frame
    send_list('{8'h00, 8'h55, 8'hAA, 8'h05, 8'h00, 8'hFB}, 20);
    chk("t2_valid", int'(bus.frm_valid), 1);
    chk("t2_len",   int'(bus.frm_len),   0);
    chk("t2_cmd",   int'(bus.frm_cmd),   8'h05);
    do_ack();
    repeat (5) tick();

    // 3. bad checksum, then good frame
    send_list('{8'hAA, 8'h10, 8'h02, 8'h11, 8'h22}, 20);
    send_byte(8'hBC, 0);
    chk("t3_err",  int'(bus.err),      1);
    chk("t3_code", int'(bus.err_code), 3);
    tick();
    chk("t3_err_end", int'(bus.err), 0);
    repeat (20) tick();
    send_list('{8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB}, 20);
    chk("t3_valid", int'(bus.frm_valid), 1);
    do_ack();
    repeat (5) tick();

    // 4. LEN above MAX_LEN
    send_list('{8'hAA, 8'h10}, 20);
    send_byte(8'h11, 0);
    chk("t4_err",  int'(bus.err),      1);
    chk("t4_code", int'(bus.err_code), 2);
    chk("t4_busy", int'(bus.busy),     0);
    repeat (20) tick();

    // 5. timeout boundary: 199 idle cycles survive, 200 abort
    send_byte(8'hAA, 20);
    send_byte(8'h10, 199);
    send_byte(8'h02, 0);
    chk("t5_no_tmo", int'(bus.err), 0);
    chk("t5_busy",   int'(bus.busy), 1);
    repeat (199) tick();
    chk("t5_pre_tmo", int'(bus.err), 0);
    tick();
    chk("t5_err",  int'(bus.err),      1);
    chk("t5_code", int'(bus.err_code), 1);
    repeat (20) tick();

    // 6. overrun, ack with simultaneous SOF, reset mid-payload
    send_list('{8'hAA, 8'h20, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD7}, 20);
    chk("t6_valid", int'(bus.frm_valid), 1);
    send_byte(8'h33, 0);
    chk("t6_ovr",  int'(bus.ovr),     1);
    chk("t6_cmd",  int'(bus.frm_cmd), 8'h20);
    bus.rd_addr = 4'd2; tick();
    chk("t6_rd2", int'(bus.rd_data), 8'h03);
    bus.rcv = 1'b1; bus.data = 8'hAA; bus.frm_ack = 1'b1;
    tick();
    bus.rcv = 1'b0; bus.frm_ack = 1'b0;
    chk("t6_ack_valid", int'(bus.frm_valid), 0);
    chk("t6_ack_busy",  int'(bus.busy),      1);
    repeat (20) tick();
    send_list('{8'h30, 8'h01, 8'h44, 8'h8B}, 20);
    chk("t6_valid2", int'(bus.frm_valid), 1);
    chk("t6_cmd2",   int'(bus.frm_cmd),   8'h30);
    do_ack();
    repeat (5) tick();
    send_list('{8'hAA, 8'h10, 8'h04, 8'h01, 8'h02}, 5);
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("t6_rst_busy",  int'(bus.busy),      0);
    chk("t6_rst_err",   int'(bus.err),       0);
    chk("t6_rst_valid", int'(bus.frm_valid), 0);
    repeat (5) tick();

    // Randomized frames: good, corrupted checksum, bad length, truncated,
    // near-timeout gaps, junk, overruns and ack/SOF collisions.
    rd_rand = 1'b1;
    for (int f = 0; f < 80; f++) begin
      q.delete();
      len  = $urandom_range(0, MAX_LEN);
      kind = $urandom_range(0, 7);
      if (kind == 5) begin
        repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
      end
      q.push_back(SOF);
      q.push_back(8'($urandom));
      q.push_back(8'(len));
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      cs = '0;
      for (int i = q.size() - len - 2; i < q.size(); i++) cs = cs - q[i];
      q.push_back(cs);
      if (kind == 0) q[q.size() - 1] = cs ^ 8'($urandom_range(1, 255));
      if (kind == 1) q[q.size() - len - 2] = 8'($urandom_range(MAX_LEN + 1, 255));
      cut = (kind == 2) ? $urandom_range(1, q.size() - 1) : q.size();
      for (int i = 0; i < cut; i++) begin
        if (kind == 3 && i == cut / 2)     gap = $urandom_range(TIMEOUT - 3, TIMEOUT + 1);
        else if ($urandom_range(0, 5) == 0) gap = $urandom_range(0, 2);
        else                                gap = $urandom_range(1, 25);
        send_byte(q[i], gap);
      end
      if (kind == 2) repeat (TIMEOUT + 5) tick();
      repeat ($urandom_range(0, 5)) tick();
      if (m_hold) begin
        case ($urandom_range(0, 2))
          0: do_ack();
          1: begin send_byte(8'($urandom), $urandom_range(0, 3)); do_ack(); end
          default: begin
            bus.rcv = 1'b1; bus.data = SOF; bus.frm_ack = 1'b1;
            tick();
            bus.rcv = 1'b0; bus.frm_ack = 1'b0;
          end
        endcase
      end else if ($urandom_range(0, 3) == 0) begin
        do_ack();
      end
      repeat ($urandom_range(1, 10)) tick();
    end

    repeat (TIMEOUT + 10) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
